// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: parametrised UART receiver feeding a first-word-fall-through
// receive FIFO with a valid/ready consumer port. Framing, parity and overrun
// errors are reported as one-cycle pulses and as sticky flags.
// Optional parity support is compiled in with the macro UART_RX_PARITY_EN.
module uart_rx_fifo #(
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int BAUD        = 115200,
  parameter int DATA_BITS   = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int PARITY_ODD  = 0
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          RX,
  output logic [DATA_BITS-1:0]          M_DATA,
  output logic                          M_VALID,
  input  logic                          M_READY,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL,
  output logic                          FRAME_ERR,
  output logic                          PARITY_ERR,
  output logic                          OVERRUN,
  output logic [2:0]                    ERR_STICKY,
  input  logic                          ERR_CLR
);

  localparam int CLKS_PER_BIT = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  // Synchroniser, edge history and the two older samples for the majority vote
  logic       rx_meta, rx_sync, rx_prev;
  logic [1:0] hist;

  state_t               state;
  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 frame_err_reg;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad;
  logic                 parity_err_reg;
`endif

  logic expiry;
  logic maj;
  logic push;

  // FIFO storage and pointers (one extra MSB to tell full from empty)
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 empty, full, pop, push_ok;
  logic                 overrun_reg;
  logic [2:0]           sticky_reg;

  // Two-flop synchroniser plus one-cycle history used for edge detect and voting
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
      hist    <= 2'b11;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      hist    <= {hist[0], rx_sync};
    end
  end

  // The three samples straddle counter value 1; the decision lands on expiry
  assign expiry = (baud_cnt == '0);
  assign maj    = (hist[1] & hist[0]) | (hist[1] & rx_sync) | (hist[0] & rx_sync);

  // Receive FSM: start qualification, bit sampling, stop/parity checks
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state          <= S_IDLE;
      baud_cnt       <= '0;
      bit_idx        <= '0;
      shreg          <= '0;
      frame_err_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad        <= 1'b0;
      parity_err_reg <= 1'b0;
`endif
    end else begin
      frame_err_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_reg <= 1'b0;
`endif
      if (state != S_IDLE && state != S_BREAK) begin
        baud_cnt <= expiry ? FULL_CNT : baud_cnt - 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (rx_prev && !rx_sync) begin
            baud_cnt <= HALF_CNT;
            bit_idx  <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad  <= 1'b0;
`endif
            state    <= S_START;
          end
        end
        S_START: begin
          if (expiry) begin
            state <= maj ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (expiry) begin
            shreg   <= {maj, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (expiry) begin
            par_bad <= (maj != ((^shreg) ^ PAR_ODD));
            state   <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (expiry) begin
            if (maj) begin
`ifdef UART_RX_PARITY_EN
              parity_err_reg <= par_bad;
`endif
              state <= S_IDLE;
            end else begin
              frame_err_reg <= 1'b1;
              state         <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (rx_sync) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A good word is offered to the FIFO in the stop-bit decision cycle
  always_comb begin
    push = 1'b0;
    if (state == S_STOP && expiry && maj) begin
`ifdef UART_RX_PARITY_EN
      push = !par_bad;
`else
      push = 1'b1;
`endif
    end
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = !empty && M_READY;
  assign push_ok = push && (!full || pop);

  // FIFO storage write; no reset needed since empty entries are never shown
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= shreg;
    end
  end

  // FIFO pointers and the overrun pulse for words dropped on a full FIFO
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overrun_reg <= 1'b0;
    end else begin
      overrun_reg <= push && !push_ok;
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Sticky error flags; a pulse in the clearing cycle keeps its bit set
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sticky_reg <= '0;
    end else begin
      sticky_reg <= (ERR_CLR ? 3'b000 : sticky_reg) | {OVERRUN, PARITY_ERR, FRAME_ERR};
    end
  end

  assign M_VALID    = !empty;
  assign M_DATA     = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign LEVEL      = wr_ptr - rd_ptr;
  assign FRAME_ERR  = frame_err_reg;
  assign OVERRUN    = overrun_reg;
  assign ERR_STICKY = sticky_reg;
`ifdef UART_RX_PARITY_EN
  assign PARITY_ERR = parity_err_reg;
`else
  assign PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: instance a uses default settings,
// instance b uses a 4-deep FIFO and 16 clocks per bit.
module tb_uart_rx_fifo;

  localparam int CPB_A  = 217;
  localparam int CPB_B  = 16;
  localparam int HALF_B = 8;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_IDX = 10;
`else
  localparam int STOP_IDX = 9;
`endif
  // Start edge taken on the 3rd edge after the fall, start-bit decision
  // HALF+1 edges later, then one decision per bit; the push for the stop bit
  // is written on edge P. M_READY is raised at the negedge just before it.
  localparam int P_B     = 4 + HALF_B + STOP_IDX * CPB_B;
  localparam int RDY_NEG = P_B - 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_a, rx_b, ready_a, ready_b, clr_a, clr_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic [4:0] level_a;
  logic [2:0] level_b;
  logic       fe_a, pe_a, ov_a, fe_b, pe_b, ov_b;
  logic [2:0] sticky_a, sticky_b;

  int n_tests = 0;
  int n_fail  = 0;
  int n_fe_a  = 0;
  int n_pe_a  = 0;
  int n_ov_a  = 0;
  int n_ov_b  = 0;
  int min_lvl;

  always #20 clk = ~clk;

  uart_rx_fifo dut_a (
    .CLK(clk), .RST_N(rst_n), .RX(rx_a),
    .M_DATA(data_a), .M_VALID(valid_a), .M_READY(ready_a), .LEVEL(level_a),
    .FRAME_ERR(fe_a), .PARITY_ERR(pe_a), .OVERRUN(ov_a),
    .ERR_STICKY(sticky_a), .ERR_CLR(clr_a)
  );

  uart_rx_fifo #(.BAUD(1_562_500), .FIFO_DEPTH(4)) dut_b (
    .CLK(clk), .RST_N(rst_n), .RX(rx_b),
    .M_DATA(data_b), .M_VALID(valid_b), .M_READY(ready_b), .LEVEL(level_b),
    .FRAME_ERR(fe_b), .PARITY_ERR(pe_b), .OVERRUN(ov_b),
    .ERR_STICKY(sticky_b), .ERR_CLR(clr_b)
  );

  // Pulse counters; a count of 1 after an event also proves a 1-cycle pulse
  always @(posedge clk) begin
    if (fe_a) n_fe_a <= n_fe_a + 1;
    if (pe_a) n_pe_a <= n_pe_a + 1;
    if (ov_a) n_ov_a <= n_ov_a + 1;
    if (ov_b) n_ov_b <= n_ov_b + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic drive(input int which, input logic v);
    if (which == 0) rx_a = v;
    else rx_b = v;
  endtask

  task automatic send(input int which, input logic [7:0] data, input logic stop_bit,
                      input logic bad_par);
    int cpb;
    cpb = (which == 0) ? CPB_A : CPB_B;
    @(negedge clk);
    drive(which, 1'b0);
    repeat (cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive(which, data[i]);
      repeat (cpb) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    drive(which, (^data) ^ bad_par);
    repeat (cpb) @(negedge clk);
`else
    if (bad_par) begin
      // no parity bit on the line in this build
    end
`endif
    drive(which, stop_bit);
    repeat (cpb) @(negedge clk);
  endtask

  task automatic gap();
    repeat (10) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1;
    ready_a = 1'b0; ready_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_valid", valid_a, 0);
    chk("rst_data", data_a, 0);
    chk("rst_level", level_a, 0);
    chk("rst_sticky", sticky_a, 0);
    chk("rst_frame", fe_a, 0);
    chk("rst_level_b", level_b, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Three words queued with the consumer stalled
    send(0, 8'h28, 1'b1, 1'b0); gap();
    send(0, 8'h28, 1'b1, 1'b0); gap();
    send(0, 8'h29, 1'b1, 1'b0); gap();
    chk("queue_level", level_a, 3);
    chk("queue_sticky", sticky_a, 0);
    chk("queue_valid", valid_a, 1);
    ready_a = 1'b1;
    chk("pop0", data_a, 8'h28);
    @(negedge clk); chk("pop1", data_a, 8'h28);
    @(negedge clk); chk("pop2", data_a, 8'h29);
    @(negedge clk); chk("drain_valid", valid_a, 0);
    chk("drain_level", level_a, 0);
    ready_a = 1'b0;

    // Short low glitch must be rejected silently
    rx_a = 1'b0;
    repeat (50) @(negedge clk);
    rx_a = 1'b1;
    repeat (400) @(negedge clk);
    chk("glitch_level", level_a, 0);
    chk("glitch_frame", n_fe_a, 0);
    chk("glitch_sticky", sticky_a, 0);

    // Stop bit low followed by a held-low line
    send(0, 8'h55, 1'b0, 1'b0);
    repeat (3 * CPB_A) @(negedge clk);
    rx_a = 1'b1;
    repeat (300) @(negedge clk);
    chk("ferr_pulses", n_fe_a, 1);
    chk("ferr_sticky", sticky_a, 3'b001);
    chk("ferr_level", level_a, 0);
    send(0, 8'hA5, 1'b1, 1'b0); gap();
    chk("after_ferr_level", level_a, 1);
    chk("after_ferr_data", data_a, 8'hA5);
    ready_a = 1'b1;
    @(negedge clk); ready_a = 1'b0;
    chk("after_ferr_empty", valid_a, 0);
    clr_a = 1'b1;
    @(negedge clk); clr_a = 1'b0;
    @(negedge clk);
    chk("clr_sticky", sticky_a, 0);

`ifdef UART_RX_PARITY_EN
    send(0, 8'h29, 1'b1, 1'b0); gap();
    chk("par_good_level", level_a, 1);
    chk("par_good_data", data_a, 8'h29);
    ready_a = 1'b1;
    @(negedge clk); ready_a = 1'b0;
    send(0, 8'h29, 1'b1, 1'b1); gap();
    chk("par_bad_pulses", n_pe_a, 1);
    chk("par_bad_level", level_a, 0);
    chk("par_bad_sticky", sticky_a, 3'b010);
    clr_a = 1'b1;
    @(negedge clk); clr_a = 1'b0;
    @(negedge clk);
    chk("par_clr_sticky", sticky_a, 0);
`else
    chk("par_tied_low", n_pe_a, 0);
`endif
    chk("a_no_overrun", n_ov_a, 0);

    // Overrun on the 4-deep instance
    send(1, 8'h11, 1'b1, 1'b0); gap();
    send(1, 8'h22, 1'b1, 1'b0); gap();
    send(1, 8'h33, 1'b1, 1'b0); gap();
    send(1, 8'h44, 1'b1, 1'b0); gap();
    send(1, 8'h55, 1'b1, 1'b0); gap();
    chk("ovr_level", level_b, 4);
    chk("ovr_pulses", n_ov_b, 1);
    chk("ovr_sticky", sticky_b, 3'b100);
    chk("ovr_head", data_b, 8'h11);
    clr_b = 1'b1;
    @(negedge clk); clr_b = 1'b0;
    @(negedge clk);
    chk("ovr_clr", sticky_b, 0);

    // Full FIFO with a pop in the push cycle: no overrun, level held at 4
    min_lvl = 7;
    fork
      send(1, 8'h66, 1'b1, 1'b0);
      begin
        @(negedge clk);
        repeat (RDY_NEG) @(negedge clk);
        chk("simul_head", data_b, 8'h11);
        ready_b = 1'b1;
        @(negedge clk);
        ready_b = 1'b0;
      end
      begin
        @(negedge clk);
        repeat (RDY_NEG - 5) @(negedge clk);
        repeat (10) begin
          @(negedge clk);
          if (int'(level_b) < min_lvl) min_lvl = int'(level_b);
        end
      end
    join
    gap();
    chk("simul_level", level_b, 4);
    chk("simul_min_level", min_lvl, 4);
    chk("simul_overrun", n_ov_b, 1);
    chk("simul_sticky", sticky_b, 0);
    ready_b = 1'b1;
    chk("order0", data_b, 8'h22);
    @(negedge clk); chk("order1", data_b, 8'h33);
    @(negedge clk); chk("order2", data_b, 8'h44);
    @(negedge clk); chk("order3", data_b, 8'h66);
    @(negedge clk); chk("order_empty", valid_b, 0);
    ready_b = 1'b0;

    // Reset in mid-frame empties the FIFO; the aborted frame is all ones
    // (parity bit forced high too) so the line stays high after release
    send(1, 8'h12, 1'b1, 1'b0); gap();
    chk("pre_rst_level", level_b, 1);
    fork
      send(1, 8'hFF, 1'b1, 1'b1);
      begin
        @(negedge clk);
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    repeat (20) @(negedge clk);
    chk("midrst_level", level_b, 0);
    chk("midrst_valid", valid_b, 0);
    chk("midrst_data", data_b, 0);
    send(1, 8'h5A, 1'b1, 1'b0); gap();
    chk("post_rst_level", level_b, 1);
    chk("post_rst_data", data_b, 8'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
